// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   tx_state_t           serializer states (IDLE/START/DATA/STOP)
//   DATA_BITS, STOP_BITS 8N1 frame shape
//   DEFAULT_CLKS_PER_BIT 100 MHz system clock / 1 Mbaud
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 100;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   push, push_data   write request and data (ignored while full)
//   pop, pop_data     read request (ignored while empty) and head-of-queue data
//   full, empty       derived from the registered count
//   count             entries currently stored (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data/in_valid    byte push handshake, accepted when in_ready is high
//   in_ready            FIFO not full (registered state only)
//   block               host flow control, sampled only at frame boundaries
//   tx                  registered serial line, idles high
//   fifo_count          bytes buffered, excluding the one being shifted
//   idle                registered: FIFO empty and serializer idle
// tx and idle are both one register stage behind the FSM state, so the
// line waveform and idle stay aligned with each other.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        block,
  output logic                        tx,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        idle
);

  localparam int              TW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT   = 3'(DATA_BITS - 1);

  tx_state_t     state_r;
  tx_state_t     state_next_s;
  logic [TW-1:0] timer_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          idle_r;

  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_head_s;
  logic          push_s;
  logic          pop_s;
  logic          timer_last_s;
  logic          tx_s;

  assign in_ready   = !fifo_full_s;
  assign push_s     = in_valid && !fifo_full_s;
  assign tx         = tx_r;
  assign idle       = idle_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (in_data),
    .pop       (pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; every bit-period transition waits for the timer's last cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_next_s = ST_START;
        else       state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (timer_last_s) state_next_s = ST_DATA;
        else              state_next_s = ST_START;
      end
      ST_DATA: begin
        if (timer_last_s && (bit_idx_r == LAST_BIT)) state_next_s = ST_STOP;
        else                                         state_next_s = ST_DATA;
      end
      ST_STOP: begin
        // Popping on the last stop cycle chains frames with no idle gap.
        if (timer_last_s && pop_s) state_next_s = ST_START;
        else if (timer_last_s)     state_next_s = ST_IDLE;
        else                       state_next_s = ST_STOP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: pop at a frame boundary unless held off by block, and the line level.
  always_comb begin
    timer_last_s = (timer_r == TIMER_LAST);
    pop_s        = 1'b0;
    tx_s         = 1'b1;
    if (((state_r == ST_IDLE) || ((state_r == ST_STOP) && timer_last_s)) &&
        !fifo_empty_s && !block) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    case (state_r)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_r[0];
      ST_IDLE:  tx_s = 1'b1;
      ST_STOP:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // Bit timer, bit index, shift register and the registered tx/idle outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r   <= {TW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= 1'b1;
      idle_r    <= 1'b1;
    end else begin
      // Every state or bit transition happens on the timer's last cycle, so
      // reloading there (and holding zero in IDLE) realigns the timer.
      if ((state_r == ST_IDLE) || timer_last_s) begin
        timer_r <= {TW{1'b0}};
      end else begin
        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        shift_r   <= fifo_head_s;
        bit_idx_r <= 3'd0;
      end else if ((state_r == ST_DATA) && timer_last_s) begin
        shift_r   <= {1'b0, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      tx_r   <= tx_s;
      idle_r <= fifo_empty_s && (state_r == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench for uart_tx_buffered
// with CLKS_PER_BIT=4 and FIFO_DEPTH=8. Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_uart_tx_buffered;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       block;
  logic       tx;
  logic [3:0] fifo_count;
  logic       idle;

  int errors = 0;
  int checks = 0;
  int peak   = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .block      (block),
    .tx         (tx),
    .fifo_count (fifo_count),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level for bit slot idx of an 8N1 frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0)      return 1'b0;
    else if (idx == 9) return 1'b1;
    else               return b[idx-1];
  endfunction

  // Checks one 40-cycle frame starting at the current cycle; optionally raises
  // block at the start of data slot block_at.
  task automatic check_frame(input logic [7:0] b, input int block_at);
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 4; c++) begin
        if ((bi == block_at) && (c == 0)) block = 1'b1;
        chk("frame_tx", 32'(tx), 32'(frame_bit(b, bi)));
        chk("frame_idle", 32'(idle), 32'd0);
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        tick(1);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    block    = 1'b0;

    // Reset state
    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst_n = 1'b1;
    tick(2);

    // Single byte 0xA5: accepted at edge N, popped N+1, tx falls after N+2
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    chk("single_count_n", 32'(fifo_count), 32'd1);
    chk("single_idle_n", 32'(idle), 32'd1);
    chk("single_tx_n", 32'(tx), 32'd1);
    tick(1);
    chk("single_count_n1", 32'(fifo_count), 32'd0);
    chk("single_idle_n1", 32'(idle), 32'd0);
    chk("single_tx_n1", 32'(tx), 32'd1);
    tick(1);
    check_frame(8'hA5, -1);
    chk("single_idle_end", 32'(idle), 32'd1);
    chk("single_tx_end", 32'(tx), 32'd1);
    tick(3);

    // Burst 0x00, 0xFF, 0x55: three contiguous frames, count peaks at 2
    peak     = 0;
    in_data  = 8'h00;
    in_valid = 1'b1;
    tick(1);
    in_data  = 8'hFF;
    tick(1);
    in_data  = 8'h55;
    tick(1);
    in_valid = 1'b0;
    chk("burst_count", 32'(fifo_count), 32'd2);
    check_frame(8'h00, -1);
    check_frame(8'hFF, -1);
    check_frame(8'h55, -1);
    chk("burst_peak", 32'(peak), 32'd2);
    chk("burst_idle_end", 32'(idle), 32'd1);
    tick(3);

    // Full FIFO under block: 8 accepted, 9th refused
    block    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h10 + 8'(i);
      chk("full_ready_before", 32'(in_ready), 32'd1);
      tick(1);
    end
    chk("full_ready_low", 32'(in_ready), 32'd0);
    chk("full_count8", 32'(fifo_count), 32'd8);
    in_data = 8'h18;
    tick(2);
    chk("full_count_held", 32'(fifo_count), 32'd8);
    chk("full_ready_held", 32'(in_ready), 32'd0);
    chk("full_tx_blocked", 32'(tx), 32'd1);
    in_valid = 1'b0;
    block    = 1'b0;
    tick(1);
    chk("full_ready_recover", 32'(in_ready), 32'd1);
    chk("full_count7", 32'(fifo_count), 32'd7);
    tick(1);
    for (int f = 0; f < 8; f++) begin
      check_frame(8'h10 + 8'(f), -1);
    end
    chk("full_drain_idle", 32'(idle), 32'd1);
    chk("full_drain_count", 32'(fifo_count), 32'd0);
    tick(3);

    // Block raised mid-frame: frame 1 completes, frame 2 held
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick(1);
    in_data  = 8'hC3;
    tick(1);
    in_valid = 1'b0;
    tick(1);
    check_frame(8'h3C, 3);
    for (int i = 0; i < 5; i++) begin
      chk("blk_tx_high", 32'(tx), 32'd1);
      chk("blk_count", 32'(fifo_count), 32'd1);
      chk("blk_idle", 32'(idle), 32'd0);
      tick(1);
    end
    block = 1'b0;
    tick(1);
    chk("blk_release_count", 32'(fifo_count), 32'd0);
    chk("blk_release_tx", 32'(tx), 32'd1);
    tick(1);
    check_frame(8'hC3, -1);
    chk("blk_idle_end", 32'(idle), 32'd1);
    tick(3);

    // Push on the STOP last-cycle pop edge with 3 queued: count stays 3
    in_data  = 8'h81;
    in_valid = 1'b1;
    tick(1);
    in_data  = 8'h42;
    tick(1);
    in_data  = 8'h99;
    tick(1);
    in_data  = 8'h66;
    tick(1);
    in_valid = 1'b0;
    chk("sim_count3", 32'(fifo_count), 32'd3);
    tick(37);
    chk("sim_count_pre", 32'(fifo_count), 32'd3);
    chk("sim_tx_stop", 32'(tx), 32'd1);
    in_data  = 8'hE7;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    chk("sim_count_post", 32'(fifo_count), 32'd3);
    tick(1);
    chk("sim_next_start", 32'(tx), 32'd0);

    // Reset during data bit 3 of 0x42 (bit 3 is 0)
    tick(17);
    chk("rstmid_tx_bit3", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_async", 32'(tx), 32'd1);
    chk("rstmid_count", 32'(fifo_count), 32'd0);
    chk("rstmid_idle", 32'(idle), 32'd1);
    chk("rstmid_ready", 32'(in_ready), 32'd1);
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      chk("rstmid_quiet_tx", 32'(tx), 32'd1);
      chk("rstmid_quiet_idle", 32'(idle), 32'd1);
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter that drives the `usb_tx` serial line. It is the transmit-side counterpart to the board's serial receive path, replacing the current raw `usb_rx`→`usb_tx` echo in the top level. Bytes are pushed over a valid/ready handshake into a small FIFO, then serialized as 8N1 frames: one start bit, eight data bits LSB first, one stop bit.

## Interface
- `CLKS_PER_BIT`, 100: clock cycles per serial bit (100 MHz / 1 Mbaud); must be ≥ 2.
- `FIFO_DEPTH`, 8: byte buffer depth; must be a power of two and ≥ 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a byte.
- `block`  in  1  host flow control; while high, no new frame starts.
- `tx`  out  1  serial line; idle level is high.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered; excludes the byte being shifted.
- `idle`  out  1  FIFO empty and serializer in IDLE.

## Operation
- **Reset values:** `tx`=1, `in_ready`=1, `fifo_count`=0, `idle`=1, FSM=IDLE, FIFO flushed.
- **Push:** a byte is written on any edge where `in_valid && in_ready`.
  - `in_ready` = !full, driven from registered state only; no combinational path from `in_valid`.
- **Pop:** the serializer pops the FIFO head when it is at a frame boundary, the FIFO is non-empty and `block`=0.
  - A frame boundary is IDLE, or the last cycle of STOP.
  - A push and a pop on the same edge leave `fifo_count` unchanged.
  - A push while full is impossible, because `in_ready`=0.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START on pop; `tx`=1 while in IDLE.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit.
    - The shift register shifts right once per bit.
    - A 3-bit index counts bits 0..7; STOP follows bit 7.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles.
    - On the last cycle, pop if possible and go to START. Back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- **Bit timer:** counter width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit transition.
- **`block`:** sampled only at frame boundaries. Asserting it mid-frame never truncates the current frame; the next frame is held until `block`=0.
- **Mid-operation reset:** `tx` returns high immediately (asynchronous) and the partial frame is abandoned. Buffered bytes are lost.
- **Output registering:** `tx` comes from a flop with no glitches. `idle` is registered-equivalent, i.e. derived purely from state.

## Timing
- **First-byte latency:** byte accepted at edge N into an empty FIFO with the FSM in IDLE and `block`=0.
  - Popped at edge N+1.
  - `tx` falls after edge N+2.
  - `idle` deasserts after edge N+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles. Throughput is one byte per 10×CLKS_PER_BIT cycles while the FIFO is non-empty.
- **`in_ready` recovery:** rises the cycle after a pop from a full FIFO.
- **`fifo_count`:** updates one cycle after the push or pop edge that changed it.

## Structure
- A shared package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the frame constants DATA_BITS=8 and STOP_BITS=1;
  - the default CLKS_PER_BIT.
- The natural sub-module is `sync_fifo`: parameterized width and depth, push/pop, full/empty/count, and the same `clk`/`rst_n` scheme. It is reusable later by the receiver path.
- The serializer FSM, bit timer and shift register live in `uart_tx_buffered` itself.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- **Single byte:** push 0xA5 into an idle block → `tx` low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. `idle` returns to 1 after 40 cycles.
- **Burst:** push 0x00, 0xFF, 0x55 back-to-back → three contiguous 40-cycle frames with no idle cycle between them. `fifo_count` peaks at 2.
- **Full FIFO:** with `block`=1, push 9 bytes → `in_ready` falls after the 8th accept and the 9th byte is not taken; `fifo_count`=8. Release `block` → `in_ready` rises 1 cycle after the first pop.
- **Mid-frame block:** assert `block` during the DATA bits of frame 1 with 2 bytes queued → frame 1 completes, `tx` stays high and `fifo_count`=1. Deasserting `block` starts frame 2 within 1 cycle.
- **Reset mid-frame:** pulse `rst_n` low during DATA bit 3 → `tx`=1 without waiting for a clock, `fifo_count`=0, `idle`=1, and no further frame is transmitted.
- **Simultaneous push and pop:** push on the STOP last-cycle pop edge with `fifo_count`=3 → `fifo_count` remains 3.
